// File: rtl/cmos_pattern_gen.sv
// rtl/cmos_pattern_gen.sv - CMOS image-sensor timing and test-pattern generator
//
// Purpose: emulates a CMOS camera parallel output (vsync/href/8-bit data)
//   carrying RGB565 test patterns, one frame after another while enabled.
//   Each frame has these phases:
//   VSYNC (VSYNC_LEN) -> VFRONT (V_FRONT)
//   -> V_ACTIVE x [HBLANK (H_BLANK) + ACTIVE (2*H_ACTIVE)] -> VBACK (V_BACK).
// Ports:
//   cmos_pclk    in   pixel clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run frames back to back while high
//   mode         in   0 ramp, 1 colour bars, 2 solid, 3 checker
//   solid_color  in   RGB565 value used by mode 2
//   cmos_vsyn    out  frame sync, active high
//   cmos_href    out  line valid, active high
//   cmos_data    out  pixel byte, high byte first, 00 outside href
//   frame_done   out  one-cycle pulse on the last cycle of a frame
//   frame_cnt    out  completed-frame counter, wraps
module cmos_pattern_gen #(
  parameter int H_ACTIVE  = 512,
  parameter int V_ACTIVE  = 8,
  parameter int H_BLANK   = 100,
  parameter int VSYNC_LEN = 1000,
  parameter int V_FRONT   = 100,
  parameter int V_BACK    = 2000
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        cmos_vsyn,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VFRONT, S_HBLANK, S_ACTIVE, S_VBACK
  } state_t;

  localparam logic [31:0] VSYNC_LAST  = 32'(VSYNC_LEN - 1);
  localparam logic [31:0] FRONT_LAST  = 32'(V_FRONT - 1);
  localparam logic [31:0] HBLANK_LAST = 32'(H_BLANK - 1);
  localparam logic [31:0] ACTIVE_LAST = 32'(2 * H_ACTIVE - 1);
  localparam logic [31:0] BACK_LAST   = 32'(V_BACK - 1);
  localparam logic [31:0] Y_LAST      = 32'(V_ACTIVE - 1);
  localparam logic [31:0] BAR_W       = 32'(H_ACTIVE / 8);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;     // cycle index within the current phase
  logic [31:0] y_q, y_d;         // active line number
  logic [1:0]  mode_q, mode_d;
  logic [15:0] solid_q, solid_d;
  logic        vsyn_q, vsyn_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic [31:0] x_full;
  logic [31:0] bar_full;
  logic [2:0]  bar;
  logic [15:0] pix;

  // Next-state logic. mode/solid_color are captured only when a frame
  // starts, so changes mid-frame have no effect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    y_d     = y_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          mode_d  = mode;
          solid_d = solid_color;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VSYNC_LAST) begin
          state_d = S_VFRONT;
          cnt_d   = '0;
        end
      end
      S_VFRONT: begin
        if (cnt_q == FRONT_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
          y_d     = '0;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HBLANK_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == ACTIVE_LAST) begin
          cnt_d = '0;
          if (y_q == Y_LAST) begin
            state_d = S_VBACK;
          end else begin
            state_d = S_HBLANK;
            y_d     = y_q + 32'd1;
          end
        end
      end
      S_VBACK: begin
        if (cnt_q == BACK_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_VSYNC;
            mode_d  = mode;
            solid_d = solid_color;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pixel generation for the byte that will be on the bus next cycle.
  // In ACTIVE the phase counter is a byte index: x = cnt/2, cnt[0] = low byte.
  always_comb begin
    x_full   = cnt_d >> 1;
    bar_full = x_full / BAR_W;
    bar      = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
    pix      = 16'h0000;
    case (mode_d)
      2'd0: pix = 16'(x_full + y_d);
      2'd1: begin
        case (bar)
          3'd0: pix = 16'hFFFF;
          3'd1: pix = 16'hFFE0;
          3'd2: pix = 16'h07FF;
          3'd3: pix = 16'h07E0;
          3'd4: pix = 16'hF81F;
          3'd5: pix = 16'hF800;
          3'd6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2: pix = solid_d;
      default: pix = (x_full[3] ^ y_d[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly
  // with the state register (vsyn high for every VSYNC cycle, etc.).
  always_comb begin
    vsyn_d = (state_d == S_VSYNC);
    href_d = (state_d == S_ACTIVE);
    data_d = 8'h00;
    if (href_d) begin
      data_d = cnt_d[0] ? pix[7:0] : pix[15:8];
    end
    done_d = (state_d == S_VBACK) && (cnt_d == BACK_LAST);
    fcnt_d = done_d ? (fcnt_q + 16'd1) : fcnt_q;
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      vsyn_q  <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      vsyn_q  <= vsyn_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cmos_vsyn  = vsyn_q;
  assign cmos_href  = href_q;
  assign cmos_data  = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule
